// File: rtl/wb_arbiter_pkg.sv
// ============================================================================
// Module      : wb_arbiter_pkg
// Description : Shared constants, types and helpers for the writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_arbiter_pkg;

    localparam logic [4:0]  REG_ADDR_ZERO  = 5'd0;
    localparam logic [31:0] ZERO_WORD      = 32'd0;
    localparam int          BUS_ADDR_REG   = 5;
    localparam int          BUS_DATA_REG   = 32;
    localparam int          WBA_DEPTH_DEF  = 2;
    localparam int          WBA_STARVE_DEF = 4;
    localparam int          ENTRY_W        = BUS_ADDR_REG + BUS_DATA_REG;

    typedef struct packed {
        logic [BUS_ADDR_REG-1:0] rd;
        logic [BUS_DATA_REG-1:0] data;
    } mdu_entry_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_MDU  = 2'd2
    } grant_t;

    // One-hot register mask; x0 maps to an empty mask since it is never tracked.
    function automatic logic [31:0] reg_mask(input logic [4:0] addr);
        logic [31:0] m;
        m = 32'd1 << addr;
        return m & ~32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wba_fifo.sv
// ============================================================================
// Module      : wba_fifo
// Description : DEPTH-entry MDU result FIFO, registered head, no bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wba_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WBA_DEPTH_DEF,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    assign full  = (r_count == C_DEPTH);
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module      : wb_arbiter
// Description : Shares the register-file write port between pipeline writeback
//               and queued MDU results; tracks MDU-owned destinations.
//               Optional statistics counters enabled by WBA_STAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH      = WBA_DEPTH_DEF,
    parameter int STARVE_MAX = WBA_STARVE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    input  logic        wb_en_i,
    input  logic        mdu_valid_i,
    input  logic [4:0]  mdu_rd_i,
    input  logic [31:0] mdu_data_i,
    output logic        mdu_ready_o,
    input  logic        issue_en_i,
    input  logic [4:0]  issue_rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    output logic        hazard_o,
    output logic        hold_n_o,
    output logic        rf_wr_en_o,
    output logic [4:0]  rf_wr_addr_o,
    output logic [31:0] rf_wr_data_o
`ifdef WBA_STAT_EN
    ,
    output logic [31:0] stat_force_o,
    output logic [31:0] stat_mdu_wr_o
`endif
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_MAX);

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_force;
    logic        w_pipe_req;
    logic        w_mdu_gnt;
    grant_t      w_gnt;
    mdu_entry_t  w_head;
    mdu_entry_t  w_din;
    logic [SW-1:0] r_starve;
    logic [31:0] r_busy;

    assign w_din  = '{rd: mdu_rd_i, data: mdu_data_i};
    assign w_push = mdu_valid_i & mdu_ready_o;

    wba_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_mdu_gnt),
        .din   (w_din),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    assign mdu_ready_o = ~rst & ~w_full;
    assign w_pipe_req  = wb_en_i & (wb_addr_i != REG_ADDR_ZERO);
    assign w_force     = ~rst & ~w_empty & (r_starve == C_STARVE_MAX);

    always_comb begin
        w_gnt        = GNT_NONE;
        w_mdu_gnt    = 1'b0;
        hold_n_o     = ~w_force;
        rf_wr_en_o   = 1'b0;
        rf_wr_addr_o = REG_ADDR_ZERO;
        rf_wr_data_o = ZERO_WORD;
        if (!rst) begin
            if (w_force) begin
                w_gnt = GNT_MDU;
            end else if (w_pipe_req) begin
                w_gnt = GNT_PIPE;
            end else if (!w_empty) begin
                w_gnt = GNT_MDU;
            end
        end
        case (w_gnt)
            GNT_PIPE: begin
                rf_wr_en_o   = 1'b1;
                rf_wr_addr_o = wb_addr_i;
                rf_wr_data_o = wb_data_i;
            end
            GNT_MDU: begin
                // An rd=0 entry still consumes the grant but never writes.
                w_mdu_gnt = 1'b1;
                if (w_head.rd != REG_ADDR_ZERO) begin
                    rf_wr_en_o   = 1'b1;
                    rf_wr_addr_o = w_head.rd;
                    rf_wr_data_o = w_head.data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_empty || w_mdu_gnt) begin
            r_starve <= '0;
        end else if (r_starve != C_STARVE_MAX) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Set is applied after clear so a same-cycle issue keeps the register busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~(w_mdu_gnt ? reg_mask(w_head.rd) : 32'd0))
                    | (issue_en_i ? reg_mask(issue_rd_i) : 32'd0);
        end
    end

    assign hazard_o = ~rst & (r_busy[rs1_i] | r_busy[rs2_i] | r_busy[rd_i]);

`ifdef WBA_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_force_o  <= '0;
            stat_mdu_wr_o <= '0;
        end else begin
            if (w_force) begin
                stat_force_o <= stat_force_o + 32'd1;
            end
            if (w_mdu_gnt && rf_wr_en_o) begin
                stat_mdu_wr_o <= stat_mdu_wr_o + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback stage and a long-latency multiply/divide unit (MDU).
- MDU results are queued in a small FIFO and drained into idle write-port cycles; a starvation timer forces a one-cycle pipeline hold to drain them.
- A destination scoreboard tracks MDU-owned registers and raises a RAW/WAW hazard to issue.
- Sits between the writeback pipeline register, the MDU and the register file.

Parameters:
- DEPTH, 2, MDU result FIFO entries (power of two, ≥2).
- STARVE_MAX, 4, consecutive non-granted cycles with FIFO non-empty before a forced grant (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- wb_addr_i  in  5  pipeline writeback destination
- wb_data_i  in  32  pipeline writeback data
- wb_en_i  in  1  pipeline writeback write enable
- mdu_valid_i  in  1  MDU result valid
- mdu_rd_i  in  5  MDU result destination
- mdu_data_i  in  32  MDU result data
- mdu_ready_o  out  1  FIFO can accept
- issue_en_i  in  1  MDU instruction issued this cycle
- issue_rd_i  in  5  its destination
- rs1_i, rs2_i, rd_i  in  5 each  issuing instruction's operands/destination
- hazard_o  out  1  issuing instruction must stall
- hold_n_o  out  1  0 = hold all pipeline stage registers this cycle
- rf_wr_en_o  out  1  register-file write enable
- rf_wr_addr_o  out  5  register-file write address
- rf_wr_data_o  out  32  register-file write data

Behaviour:
- Reset: FIFO empty, scoreboard clear, starve counter 0. While rst=1: rf_wr_en_o=0, hold_n_o=1, mdu_ready_o=0, hazard_o=0. After reset: mdu_ready_o=1, rf_wr_addr_o=0, rf_wr_data_o=0.
- pipe_req = wb_en_i & (wb_addr_i≠0). fifo_req = FIFO non-empty.
- Grant (combinational, per cycle):
  - force = fifo_req & (starve_cnt==STARVE_MAX).
  - When force=1: grant MDU head and drive hold_n_o=0. The held WB stage replays its write next cycle; the write is idempotent.
  - Otherwise, when pipe_req=1: grant pipeline.
  - Otherwise, when fifo_req=1: grant MDU head.
  - Otherwise: rf_wr_en_o=0.
- A write with address 0 is never issued. An MDU entry with rd=0 is popped silently and counts as a grant.
- Write port is combinational from the granted source. The FIFO head pops on the same edge.
- starve_cnt: reset to 0 on any MDU grant or when the FIFO is empty; otherwise increment, saturating at STARVE_MAX.
- FIFO:
  - Push on mdu_valid_i & mdu_ready_o; mdu_ready_o = !full.
  - Push and pop in the same cycle is legal at any occupancy, including full: the pop frees the slot next cycle, and the push is blocked at full because ready is low.
  - Pointers wrap modulo DEPTH.
  - Latency: a result accepted at edge t is writable earliest in the cycle after t. No same-cycle bypass.
- Scoreboard (32-bit busy, bit 0 hardwired 0):
  - issue_en_i sets busy[issue_rd_i].
  - An MDU grant clears busy[head rd].
  - Set and clear of the same register in the same cycle: set wins.
- hazard_o = busy[rs1_i] | busy[rs2_i] | busy[rd_i], combinational. Issue must not assert issue_en_i while hazard_o=1.
- Reset asserted mid-operation discards FIFO contents and the scoreboard. The MDU must flush itself on the same reset.

Optional Feature:
- WBA_STAT_EN defined: adds outputs stat_force_o[31:0] and stat_mdu_wr_o[31:0].
  - stat_force_o counts forced-hold cycles; stat_mdu_wr_o counts MDU writes.
  - Both wrap at 2^32 and are cleared by rst.
- WBA_STAT_EN undefined: the ports and counters are absent. No other behaviour changes.

Decomposition:
- Shared define header: REG_ADDR_ZERO, ZERO_WORD, BUS_ADDR_REG, BUS_DATA_REG, plus new WBA_DEPTH_DEF and WBA_STARVE_DEF.
- One sub-module, wba_fifo: parameterised DEPTH × 37-bit FIFO exposing full, empty, head and push/pop.
- Grant logic, starve counter and scoreboard stay in wb_arbiter.

Test Plan:
- Reset release, all inputs idle → mdu_ready_o=1, hold_n_o=1, rf_wr_en_o=0, hazard_o=0 on the first post-reset cycle.
- issue_en_i with rd=5, then mdu result (rd=5, 0xDEADBEEF) with wb_en_i=0 → hazard_o=1 while rs1_i=5 until the write. rf write of x5=0xDEADBEEF one cycle after acceptance. hazard_o=0 the following cycle.
- wb_en_i=1 to x3 held continuously, one MDU entry queued, STARVE_MAX=4 → pipeline writes x3 for 4 cycles. 5th cycle: hold_n_o=0 and the MDU entry is written. Next cycle the pipeline writes x3 again.
- Push 2 results back-to-back (DEPTH=2) while the pipeline writes → mdu_ready_o=0 after the second push. Same-cycle push attempt plus pop → no push that cycle; ready=1 next cycle; entries are written in FIFO order.
- issue_en_i rd=7 in the same cycle an MDU grant clears x7 → busy[7] stays 1. MDU result with rd=0 → popped, no rf write. rst asserted with 2 entries queued → FIFO empties, busy clears.
